// File: rtl/pipe_adder_pkg.sv
// Shared constants and types for the pipelined adder/subtractor.
package pipe_adder_pkg;

   localparam int unsigned WIDTH_DEF  = 16;
   localparam int unsigned STAGES_DEF = 4;

   typedef enum logic {
      MODE_ADD = 1'b0,
      MODE_SUB = 1'b1
   } mode_t;

   // Flags produced by each slice; only the final stage's ovf reaches the port.
   typedef struct packed {
      logic carry;
      logic ovf;
   } stage_flags_t;

endpackage

// File: rtl/pipe_add_stage.sv
// One registered SLICE-bit adder slice with valid/load control; operands and
// partial sum travel alongside so later slices see aligned data.
module pipe_add_stage
   import pipe_adder_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned SLICE = WIDTH_DEF / STAGES_DEF,
   parameter int unsigned K     = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               v_in,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
   input  logic [WIDTH-1:0]   sum_in,
   input  logic               c_in,
   output logic               valid,
   output logic [WIDTH-1:0]   a_q,
   output logic [WIDTH-1:0]   b_q,
   output logic [WIDTH-1:0]   sum_q,
   output stage_flags_t       flag_q
);

   localparam int unsigned LSB = K * SLICE;

   logic [SLICE:0]     ext_c;
   logic [WIDTH-1:0]   sum_nx_c;
   stage_flags_t       flag_nx_c;

   // Slice add; carry into the slice MSB is recovered from the sum bit.
   always_comb begin
      ext_c    = {1'b0, a_in[LSB +: SLICE]} + {1'b0, b_in[LSB +: SLICE]}
                 + (SLICE+1)'(c_in);
      sum_nx_c = sum_in;
      sum_nx_c[LSB +: SLICE] = ext_c[SLICE-1:0];
      flag_nx_c.carry = ext_c[SLICE];
      flag_nx_c.ovf   = ext_c[SLICE] ^
                        (ext_c[SLICE-1] ^ a_in[LSB+SLICE-1] ^ b_in[LSB+SLICE-1]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid  <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         sum_q  <= '0;
         flag_q <= '0;
      end else if (load) begin
         valid  <= v_in;
         a_q    <= a_in;
         b_q    <= b_in;
         sum_q  <= sum_nx_c;
         flag_q <= flag_nx_c;
      end
   end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder/subtractor, one SLICE-bit slice per stage, with
// valid/ready flow control and a combinational ready chain.
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int unsigned WIDTH  = WIDTH_DEF,
   parameter int unsigned STAGES = STAGES_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               cin,
   input  logic               sub,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   sum,
   output logic               cout,
   output logic               ovf
);

   localparam int unsigned SLICE = WIDTH / STAGES;

   if (WIDTH < 2) begin : g_bad_width
      $error("pipe_adder: WIDTH must be at least 2");
   end
   if (STAGES == 0 || (WIDTH % STAGES) != 0) begin : g_bad_stages
      $error("pipe_adder: STAGES must divide WIDTH exactly");
   end

   mode_t              mode_c;
   logic [WIDTH-1:0]   b_eff_c;
   logic               carry0_c;

   logic [WIDTH-1:0]   a_in_s   [STAGES];
   logic [WIDTH-1:0]   b_in_s   [STAGES];
   logic [WIDTH-1:0]   sum_in_s [STAGES];
   logic               c_in_s   [STAGES];
   logic               v_in_s   [STAGES];

   logic [WIDTH-1:0]   a_s      [STAGES];
   logic [WIDTH-1:0]   b_s      [STAGES];
   logic [WIDTH-1:0]   sum_s    [STAGES];
   stage_flags_t       flag_s   [STAGES];
   logic [STAGES-1:0]  valid_s;
   logic [STAGES-1:0]  load_c;

   assign mode_c = mode_t'(sub);

   // Subtraction is a + ~b + 1; cin only matters when adding.
   always_comb begin
      b_eff_c  = b;
      carry0_c = cin;
      if (mode_c == MODE_SUB) begin
         b_eff_c  = ~b;
         carry0_c = 1'b1;
      end
   end

   // A stage loads if it, or any stage downstream of it, is empty, or the sink is ready.
   always_comb begin : load_chain
      logic go;
      go     = out_ready;
      load_c = '0;
      for (int k = int'(STAGES) - 1; k >= 0; k--) begin
         go        = go | ~valid_s[k];
         load_c[k] = go;
      end
   end

   for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
      if (k == 0) begin : g_head
         assign v_in_s[k]   = in_valid;
         assign a_in_s[k]   = a;
         assign b_in_s[k]   = b_eff_c;
         assign sum_in_s[k] = '0;
         assign c_in_s[k]   = carry0_c;
      end else begin : g_body
         assign v_in_s[k]   = valid_s[k-1];
         assign a_in_s[k]   = a_s[k-1];
         assign b_in_s[k]   = b_s[k-1];
         assign sum_in_s[k] = sum_s[k-1];
         assign c_in_s[k]   = flag_s[k-1].carry;
      end

      pipe_add_stage #(
         .WIDTH (WIDTH),
         .SLICE (SLICE),
         .K     (k)
      ) u_stage (
         .clk    (clk),
         .rst    (rst),
         .load   (load_c[k]),
         .v_in   (v_in_s[k]),
         .a_in   (a_in_s[k]),
         .b_in   (b_in_s[k]),
         .sum_in (sum_in_s[k]),
         .c_in   (c_in_s[k]),
         .valid  (valid_s[k]),
         .a_q    (a_s[k]),
         .b_q    (b_s[k]),
         .sum_q  (sum_s[k]),
         .flag_q (flag_s[k])
      );
   end

   assign in_ready  = load_c[0];
   assign out_valid = valid_s[STAGES-1];
   assign sum       = sum_s[STAGES-1];
   assign cout      = flag_s[STAGES-1].carry;
   assign ovf       = flag_s[STAGES-1].ovf;

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder (16-bit, 4 stages): driver pushes expected
// results on acceptance, monitor pops and compares on each output transfer.
module tb_pipe_adder;

   localparam int unsigned W = 16;
   localparam int unsigned S = 4;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          cin;
   logic          sub;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  sum;
   logic          cout;
   logic          ovf;

   typedef struct {
      logic [W-1:0] s;
      logic         c;
      logic         o;
      int           cyc;
      bit           lat;
   } exp_t;

   exp_t sbq[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   bit   lat_mode = 1'b1;

   pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   // Reference: signed/unsigned arithmetic straight from the operation's meaning.
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic ci, input logic md);
      exp_t e;
      int   sx, sy, r;
      int   ux, uy;
      sx = int'($signed(x));
      sy = int'($signed(y));
      ux = int'(x);
      uy = int'(y);
      r  = md ? (sx - sy) : (sx + sy + int'(ci));
      e.s   = md ? W'(ux - uy) : W'(ux + uy + int'(ci));
      e.c   = md ? (ux >= uy) : ((ux + uy + int'(ci)) > 65535);
      e.o   = (r > 32767) || (r < -32768);
      e.cyc = 0;
      e.lat = 1'b0;
      return e;
   endfunction

   function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o);
      exp_t e;
      e.s = s; e.c = c; e.o = o; e.cyc = 0; e.lat = 1'b0;
      return e;
   endfunction

   // One cycle of stimulus; pushes the expectation if the beat is accepted.
   task automatic drive(input bit v, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tc, input logic ts, input logic orv,
                        input exp_t e, output bit acc);
      exp_t q;
      in_valid  = v;
      a         = ta;
      b         = tb_;
      cin       = tc;
      sub       = ts;
      out_ready = orv;
      @(negedge clk);
      acc = v && in_ready && !rst;
      if (acc) begin
         q     = e;
         q.cyc = cyc;
         q.lat = lat_mode;
         sbq.push_back(q);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                       input logic ts, input exp_t e);
      bit acc;
      int n;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 50) begin
         drive(1'b1, ta, tb_, tc, ts, 1'b1, e, acc);
         n++;
      end
      if (!acc) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: beat not accepted within 50 cycles");
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      bit   acc;
      exp_t e;
      int   n;
      e = mk('0, 1'b0, 1'b0);
      n = 0;
      while (sbq.size() != 0 && n < 40) begin
         drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, e, acc);
         n++;
      end
      chk("drain_pending", 32'(sbq.size()), 32'd0);
   endtask

   // Monitor: compares every transfer and watches held outputs during stalls.
   logic [W+1:0] held_v;
   bit           held;
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst) begin
         held = 1'b0;
      end else begin
         if (out_valid && !out_ready) begin
            if (held) chk("stall_hold", 32'({cout, ovf, sum}), 32'(held_v));
            held   = 1'b1;
            held_v = {cout, ovf, sum};
         end else begin
            held = 1'b0;
         end
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_out: sum 0x%0h with no beat pending", sum);
            end else begin
               e = sbq.pop_front();
               chk("result", 32'({cout, ovf, sum}), 32'({e.c, e.o, e.s}));
               if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'(S));
            end
         end else if (out_ready && sbq.size() != 0 && sbq[0].lat && (cyc - sbq[0].cyc) >= int'(S)) begin
            checks++;
            failures++;
            $display("FAIL missing_out: out_valid %0b but beat due %0d cycles ago",
                     out_valid, cyc - sbq[0].cyc - int'(S));
         end
      end
   end

   initial begin
      bit   acc;
      int   n;
      logic [W-1:0] ra, rb;
      logic rc, rs, rv, rr;

      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_result", 32'({cout, ovf, sum}), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Directed corner cases.
      lat_mode = 1'b1;
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0));
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1));
      send(16'h0005, 16'h0007, 1'b1, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
      send(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1));
      wait_drain();

      // Back-to-back stream.
      for (int i = 0; i < 8; i++) begin
         ra = W'(i);
         rb = W'(16'h1000 * i);
         send(ra, rb, 1'b0, 1'b0, model(ra, rb, 1'b0, 1'b0));
      end
      wait_drain();

      // Stall with continuous input: four beats fill the pipe, then ready drops.
      lat_mode = 1'b0;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
         drive(1'b1, ra, rb, rc, rs, 1'b0, model(ra, rb, rc, rs), acc);
         if (acc) n++;
      end
      chk("stall_accepted", 32'(n), 32'd4);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      in_valid = 1'b0;
      wait_drain();

      // Reset with three beats in flight.
      lat_mode = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ra = W'($urandom); rb = W'($urandom);
         send(ra, rb, 1'b0, 1'b0, model(ra, rb, 1'b0, 1'b0));
      end
      #2 rst = 1'b1;
      #1;
      chk("async_rst_out_valid", 32'(out_valid), 32'd0);
      chk("async_rst_in_ready", 32'(in_ready), 32'd1);
      chk("async_rst_result", 32'({cout, ovf, sum}), 32'd0);
      sbq.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      ra = W'($urandom); rb = W'($urandom);
      send(ra, rb, 1'b1, 1'b1, model(ra, rb, 1'b1, 1'b1));
      wait_drain();

      // Random traffic with random backpressure.
      lat_mode = 1'b0;
      for (int i = 0; i < 300; i++) begin
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
         rv = ($urandom % 4) != 0;
         rr = ($urandom % 10) < 7;
         drive(rv, ra, rb, rc, rs, rr, model(ra, rb, rc, rs), acc);
      end
      in_valid = 1'b0;
      wait_drain();

      // Random bubbles with the sink always ready: exact latency per beat.
      lat_mode = 1'b1;
      for (int i = 0; i < 80; i++) begin
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
         rv = ($urandom % 5) < 3;
         drive(rv, ra, rb, rc, rs, 1'b1, model(ra, rb, rc, rs), acc);
      end
      in_valid = 1'b0;
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand and sum width in bits; SHALL be at least 2.
REQ-002 Parameter STAGES, default 4, number of pipeline stages; SHALL divide WIDTH exactly, with SLICE = WIDTH/STAGES bits per stage.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in; used only when sub=0.
REQ-010 sub  input  1  mode: 0 selects a+b+cin, 1 selects a-b.
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry out of the MSB.
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 A beat SHALL be accepted when in_valid and in_ready are both high; a result SHALL be transferred when out_valid and out_ready are both high.
REQ-017 sub=1: the block SHALL compute a + ~b + 1 and ignore cin; cout=1 means no borrow.
REQ-018 sub=0: the block SHALL compute a + b + cin.
REQ-019 Stage k (0..STAGES-1) SHALL add bit slice [k*SLICE +: SLICE] using the carry registered by stage k-1; stage 0 SHALL use the mode carry-in.
REQ-020 Unprocessed upper operand slices SHALL be carried forward in skew registers.
REQ-021 Completed lower sum slices SHALL be carried forward in de-skew registers.
REQ-022 Latency SHALL be exactly STAGES cycles from acceptance to out_valid when no stage is stalled.
REQ-023 Throughput SHALL be one beat per cycle while out_ready is held high.
REQ-024 Each stage SHALL hold a valid bit; stage k SHALL load when it is empty or when stage k+1 loads that cycle (k=STAGES-1 uses out_ready).
REQ-025 in_ready SHALL equal the stage 0 load condition: combinational from stage-0 valid and downstream state, with no register in the path.
REQ-026 A stalled stage SHALL hold its data and valid unchanged; beats SHALL never be dropped, duplicated or reordered.
REQ-027 ovf SHALL be computed in the final stage as the carry into the MSB XOR the carry out of the MSB.
REQ-028 sum, cout and ovf SHALL be driven directly from final-stage registers and SHALL be stable while out_valid=1 and out_ready=0.
REQ-029 When the pipeline is full and out_ready=0, in_ready SHALL be 0 in the same cycle.
REQ-030 When the pipeline is full and out_ready=1, a new beat SHALL be accepted in the same cycle the oldest result leaves.
REQ-031 in_valid=0 SHALL insert bubbles; out_valid SHALL be 0 for exactly the corresponding cycles.

Reset
REQ-032 Asserting rst SHALL immediately clear all stage valid bits, giving out_valid=0 and in_ready=1 without waiting for a clock edge.
REQ-033 Asserting rst SHALL immediately clear sum, cout and ovf to 0.
REQ-034 Reset mid-operation SHALL discard all in-flight beats; no beat accepted before reset SHALL appear after reset.
REQ-035 The first beat after deassertion SHALL be accepted on the first rising edge with rst low.

Structure
REQ-036 Shared package pipe_adder_pkg SHALL hold the default WIDTH/STAGES constants, the mode enum (MODE_ADD, MODE_SUB) and the per-stage payload struct type.
REQ-037 Sub-module pipe_add_stage SHALL implement one SLICE-bit registered adder slice with valid/load control, instantiated STAGES times by generate.
REQ-038 Elaboration SHALL fail if WIDTH % STAGES != 0.

Verification (WIDTH=16, STAGES=4)
REQ-039 a=0xFFFF, b=0x0001, cin=0, sub=0 -> 4 cycles later sum=0x0000, cout=1, ovf=0.
REQ-040 a=0x7FFF, b=0x0001, cin=0, sub=0 -> sum=0x8000, cout=0, ovf=1.
REQ-041 a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0 (cin ignored).
REQ-042 8 back-to-back beats (a=i, b=0x1000*i, i=0..7) with out_ready=1 -> 8 consecutive out_valid cycles starting 4 cycles after the first, in order, each result correct.
REQ-043 Continuous in_valid with out_ready=0 for 6 cycles -> in_ready falls after 4 beats are accepted; out_valid and sum are stable during the stall; all beats emerge once out_ready=1.
REQ-044 rst pulse while 3 beats are in flight -> out_valid=0 immediately with no clock edge required; none of the 3 beats appears after reset; the next beat appears 4 cycles after its acceptance.
